// File: rtl/lpm_table_sched.sv
// lpm_table_sched: longest-prefix-match route table with a sequential lookup scan
// sharing one table port with host reads/writes (host accesses win and stall the scan).
module lpm_table_sched #(
    parameter int NUM_ENTRIES = 32,
    parameter int ENTRY_WIDTH = 128,
    localparam int IW = $clog2(NUM_ENTRIES)
) (
    input  logic                   AXI_ACLK,
    input  logic                   reset,
    input  logic                   tbl_wr_req,
    input  logic [IW-1:0]          tbl_wr_addr,
    input  logic [ENTRY_WIDTH-1:0] tbl_wr_data,
    output logic                   tbl_wr_ack,
    input  logic                   tbl_rd_req,
    input  logic [IW-1:0]          tbl_rd_addr,
    output logic [ENTRY_WIDTH-1:0] tbl_rd_data,
    output logic                   tbl_rd_ack,
    input  logic                   lkup_req,
    input  logic [31:0]            lkup_ip,
    output logic                   lkup_ready,
    output logic                   lkup_done,
    output logic                   lkup_hit,
    output logic [31:0]            lkup_nh,
    output logic [30:0]            lkup_oq,
    output logic [31:0]            lkup_mask,
    input  logic                   miss_clr,
    output logic [31:0]            lpm_miss_count
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;
    logic [ENTRY_WIDTH-1:0] mem [NUM_ENTRIES];
    logic [ENTRY_WIDTH-1:0] entry;
    logic [IW-1:0] idx, rd_addr_q, rd_addr_eff, acc_addr;
    logic [31:0] ip_q, best_nh, best_mask;
    logic [30:0] best_oq;
    logic best_hit, rd_pend, wr_go, rd_go, step, take, last;
    // A write is always served in its request cycle; a read colliding with it waits one cycle.
    assign wr_go       = tbl_wr_req;
    assign rd_go       = !wr_go && (rd_pend || tbl_rd_req);
    assign rd_addr_eff = rd_pend ? rd_addr_q : tbl_rd_addr;
    assign acc_addr    = wr_go ? tbl_wr_addr : (rd_go ? rd_addr_eff : idx);
    assign entry       = mem[acc_addr];
    assign step        = (state == SCAN) && !wr_go && !rd_go;
    assign last        = idx == IW'(NUM_ENTRIES - 1);
    assign take        = entry[127] && ((ip_q & entry[63:32]) == (entry[31:0] & entry[63:32]))
                         && (!best_hit || entry[63:32] > best_mask);
    assign lkup_ready  = state == IDLE;
    always_ff @(posedge AXI_ACLK)
        if (wr_go && !reset) mem[tbl_wr_addr] <= tbl_wr_data;
    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            ip_q        <= '0;
            best_hit    <= 1'b0;
            best_nh     <= '0;
            best_oq     <= '0;
            best_mask   <= '0;
            rd_pend     <= 1'b0;
            rd_addr_q   <= '0;
            tbl_wr_ack  <= 1'b0;
            tbl_rd_ack  <= 1'b0;
            tbl_rd_data <= '0;
            lkup_done   <= 1'b0;
            lkup_hit    <= 1'b0;
            lkup_nh     <= '0;
            lkup_oq     <= '0;
            lkup_mask   <= '0;
        end else begin
            tbl_wr_ack <= wr_go;
            tbl_rd_ack <= rd_go;
            rd_pend    <= (rd_pend || tbl_rd_req) && wr_go;
            lkup_done  <= 1'b0;
            if (tbl_rd_req) rd_addr_q <= tbl_rd_addr;
            if (rd_go) tbl_rd_data <= entry;
            case (state)
                IDLE: if (lkup_req) begin
                    state     <= SCAN;
                    ip_q      <= lkup_ip;
                    idx       <= '0;
                    best_hit  <= 1'b0;
                    best_nh   <= '0;
                    best_oq   <= '0;
                    best_mask <= '0;
                end
                SCAN: if (step) begin
                    idx <= idx + 1'b1;
                    if (take) begin
                        best_hit  <= 1'b1;
                        best_nh   <= entry[95:64];
                        best_oq   <= entry[126:96];
                        best_mask <= entry[63:32];
                    end
                    if (last) begin
                        state     <= DONE;
                        lkup_done <= 1'b1;
                        lkup_hit  <= take || best_hit;
                        lkup_nh   <= take ? entry[95:64]  : best_nh;
                        lkup_oq   <= take ? entry[126:96] : best_oq;
                        lkup_mask <= take ? entry[63:32]  : best_mask;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // Counted as the DONE cycle ends, so a clear in the lkup_done cycle overrides the miss.
    always_ff @(posedge AXI_ACLK)
        if (reset || miss_clr) lpm_miss_count <= '0;
        else if (state == DONE && !lkup_hit) lpm_miss_count <= lpm_miss_count + 1'b1;
endmodule

// File: tb/tb_lpm_table_sched.sv
// tb_lpm_table_sched: directed and randomized checks of lpm_table_sched against a
// candidate-list longest-prefix reference model of the route table.
module tb_lpm_table_sched;
    logic AXI_ACLK = 0, reset = 1;
    logic tbl_wr_req = 0, tbl_rd_req = 0, lkup_req = 0, miss_clr = 0;
    logic [4:0] tbl_wr_addr = 0, tbl_rd_addr = 0;
    logic [127:0] tbl_wr_data = 0, tbl_rd_data;
    logic tbl_wr_ack, tbl_rd_ack, lkup_ready, lkup_done, lkup_hit;
    logic [31:0] lkup_ip = 0, lkup_nh, lkup_mask, lpm_miss_count;
    logic [30:0] lkup_oq;

    lpm_table_sched dut (
        .AXI_ACLK(AXI_ACLK), .reset(reset),
        .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .tbl_wr_ack(tbl_wr_ack),
        .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack),
        .lkup_req(lkup_req), .lkup_ip(lkup_ip), .lkup_ready(lkup_ready),
        .lkup_done(lkup_done), .lkup_hit(lkup_hit), .lkup_nh(lkup_nh), .lkup_oq(lkup_oq), .lkup_mask(lkup_mask),
        .miss_clr(miss_clr), .lpm_miss_count(lpm_miss_count)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    int total = 0, bad = 0, cyc = 0, t0 = 0;
    logic [127:0] tm [32];
    logic [31:0] mc = 0;
    logic [31:0] mtab [5] = '{32'h0, 32'hFF000000, 32'hFFFF0000, 32'hFFFFFF00, 32'hFFFFFFFF};

    always @(posedge AXI_ACLK) cyc++;

    task automatic tick;
        @(posedge AXI_ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ent(input logic v, input logic [30:0] oq, input logic [31:0] nh,
                                         input logic [31:0] m, input logic [31:0] p);
        return {v, oq, nh, m, p};
    endfunction

    function automatic logic [31:0] rip();
        return {8'd10, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), 8'($urandom_range(0, 3))};
    endfunction

    // Reference: gather every valid matching entry, then the widest mask wins, earliest index on ties.
    task automatic ref_lookup(input logic [31:0] ip, output logic h, output logic [31:0] nh,
                              output logic [30:0] oq, output logic [31:0] m);
        int cand[$];
        logic [31:0] top = 0;
        bit found = 0;
        foreach (tm[i]) if (tm[i][127] && ((ip ^ tm[i][31:0]) & tm[i][63:32]) == 0) cand.push_back(i);
        foreach (cand[j]) if (tm[cand[j]][63:32] > top) top = tm[cand[j]][63:32];
        h = cand.size() > 0; nh = 0; oq = 0; m = 0;
        foreach (cand[j]) if (!found && tm[cand[j]][63:32] == top) begin
            found = 1; nh = tm[cand[j]][95:64]; oq = tm[cand[j]][126:96]; m = top;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [127:0] d);
        int n = 0;
        tbl_wr_req = 1; tbl_wr_addr = a; tbl_wr_data = d;
        tick;
        tbl_wr_req = 0; tm[a] = d;
        while (!tbl_wr_ack && n < 1) begin tick; n++; end
        chk("wr_ack", tbl_wr_ack, 1);
        tick;
    endtask

    task automatic rd(input logic [4:0] a);
        int n = 0;
        tbl_rd_req = 1; tbl_rd_addr = a;
        tick;
        tbl_rd_req = 0;
        while (!tbl_rd_ack && n < 1) begin tick; n++; end
        chk("rd_ack", tbl_rd_ack, 1);
        chk("rd_data", tbl_rd_data, tm[a]);
        tick;
    endtask

    task automatic start_lookup(input logic [31:0] ip);
        chk("ready_idle", lkup_ready, 1);
        lkup_ip = ip; lkup_req = 1;
        tick;
        lkup_req = 0; t0 = cyc;
        chk("ready_busy", lkup_ready, 0);
    endtask

    // Edges counted from the accepting edge: 32 edges puts lkup_done in cycle T+33.
    task automatic finish_lookup(input int exp_lat, input logic exp_hit, input logic clr);
        int n = 0;
        while (!lkup_done && n < 300) begin tick; n++; end
        chk("done_latency", 128'(cyc - t0), 128'(exp_lat));
        miss_clr = clr;
        tick;
        miss_clr = 0;
        chk("done_one_cycle", lkup_done, 0);
        if (clr) mc = 0; else if (!exp_hit) mc++;
        chk("miss_count", lpm_miss_count, mc);
    endtask

    task automatic expect_result(input string tag, input logic h, input logic [31:0] nh,
                                 input logic [30:0] oq, input logic [31:0] m);
        chk({tag, "_hit"}, lkup_hit, h);
        chk({tag, "_nh"}, lkup_nh, nh);
        chk({tag, "_oq"}, lkup_oq, oq);
        chk({tag, "_mask"}, lkup_mask, m);
    endtask

    initial begin
        logic h, gw, gr;
        logic [31:0] enh, em, ip;
        logic [30:0] eoq;
        logic [127:0] d, rv;
        bit seen;
        repeat (3) tick;
        reset = 0;
        chk("rst_ready", lkup_ready, 1);
        chk("rst_done", lkup_done, 0);
        chk("rst_hit", lkup_hit, 0);
        chk("rst_nh", lkup_nh, 0);
        chk("rst_oq", lkup_oq, 0);
        chk("rst_mask", lkup_mask, 0);
        chk("rst_acks", {tbl_wr_ack, tbl_rd_ack}, 0);
        chk("rst_rd_data", tbl_rd_data, 0);
        chk("rst_count", lpm_miss_count, 0);

        for (int i = 0; i < 32; i++) wr(5'(i), ent(0, 31'($urandom), $urandom, $urandom, $urandom));
        start_lookup(32'h0A000001);
        finish_lookup(32, 0, 0);
        expect_result("all_invalid", 0, 0, 0, 0);

        wr(3, ent(1, 2, 1, 32'hFF000000, 32'h0A000000));
        wr(7, ent(1, 4, 5, 32'hFFFF0000, 32'h0A010000));
        start_lookup(32'h0A010203);
        finish_lookup(32, 1, 0);
        expect_result("longest", 1, 5, 4, 32'hFFFF0000);

        start_lookup(32'hC0A80101);
        finish_lookup(32, 0, 1);
        expect_result("miss_clr", 0, 0, 0, 0);

        start_lookup(32'h0A010203);
        repeat (10) tick;
        reset = 1;
        tick;
        reset = 0;
        chk("ready_after_reset", lkup_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin seen |= lkup_done; tick; end
        chk("no_done_after_reset", seen, 0);
        chk("count_after_reset", lpm_miss_count, 0);
        rd(3);
        rd(7);

        wr(2, ent(1, 1, 11, 32'h0, 32'h0));
        wr(9, ent(1, 3, 12, 32'h0, 32'h0));
        start_lookup(32'hC0A80101);
        finish_lookup(32, 1, 0);
        expect_result("default_route", 1, 11, 1, 0);

        start_lookup(32'h0A010203);
        rd(3); rd(7); rd(2); rd(9);
        finish_lookup(36, 1, 0);
        expect_result("reads_in_scan", 1, 5, 4, 32'hFFFF0000);

        start_lookup(32'h0A010203);
        repeat (4) tick;
        wr(1, ent(1, 7, 8, 32'hFFFFFFFF, 32'h0A010203));
        wr(30, ent(1, 6, 9, 32'hFFFFFF00, 32'h0A010200));
        finish_lookup(34, 1, 0);
        expect_result("write_in_scan", 1, 9, 6, 32'hFFFFFF00);

        d = ent(0, 31'h5A5A, 32'h1234, 32'hFFFFFFFF, 32'h0B000005);
        tbl_wr_req = 1; tbl_rd_req = 1; tbl_wr_addr = 5; tbl_rd_addr = 5; tbl_wr_data = d;
        tick;
        tbl_wr_req = 0; tbl_rd_req = 0; tm[5] = d;
        gw = 0; gr = 0; rv = 0;
        for (int k = 0; k < 2; k++) begin
            if (tbl_wr_ack) gw = 1;
            if (tbl_rd_ack) begin gr = 1; rv = tbl_rd_data; end
            tick;
        end
        chk("wrrd_wr_ack", gw, 1);
        chk("wrrd_rd_ack", gr, 1);
        chk("wrrd_data", rv, d);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) begin
                int s = $urandom_range(0, 15);
                wr(5'(i), ent($urandom_range(0, 3) != 0, 31'($urandom), $urandom,
                              s == 0 ? mtab[0] : mtab[1 + s % 4], rip()));
            end
            for (int k = 0; k < 8; k++) begin
                ip = $urandom_range(0, 4) == 0 ? {8'd11, 24'($urandom)} : rip();
                ref_lookup(ip, h, enh, eoq, em);
                start_lookup(ip);
                finish_lookup(32, h, 0);
                expect_result("rand", h, enh, eoq, em);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lpm_table_sched.md
LPM_TABLE_SCHED -- requirements
Module: lpm_table_sched

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 32: number of route-table entries (index width 5).
REQ-002 SHALL have parameter ENTRY_WIDTH, default 128: entry layout [31:0] prefix IP, [63:32] netmask, [95:64] next hop, [126:96] output queue, [127] valid.
REQ-003 SHALL have port AXI_ACLK  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset, sampled on AXI_ACLK.
REQ-005 SHALL have ports tbl_wr_req  in  1, tbl_wr_addr  in  5, tbl_wr_data  in  128, tbl_wr_ack  out  1: host write, single-cycle request pulse.
REQ-006 SHALL have ports tbl_rd_req  in  1, tbl_rd_addr  in  5, tbl_rd_data  out  128, tbl_rd_ack  out  1: host read, single-cycle request pulse.
REQ-007 SHALL have ports lkup_req  in  1, lkup_ip  in  32, lkup_ready  out  1: lookup request/accept.
REQ-008 SHALL have ports lkup_done  out  1, lkup_hit  out  1, lkup_nh  out  32, lkup_oq  out  31, lkup_mask  out  32: lookup result.
REQ-009 SHALL have ports miss_clr  in  1, lpm_miss_count  out  32: miss counter and its clear.

Function
REQ-010 SHALL own the table as a single-port array (one entry access per cycle), shared between host and lookup scan.
REQ-011 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE; lkup_ready = 1 only in IDLE.
REQ-012 SHALL accept a lookup in cycle T when IDLE & lkup_req; lkup_ip latched at T; scan index cleared to 0.
REQ-013 SHALL in SCAN access one entry per cycle, index 0 to NUM_ENTRIES-1 ascending, then enter DONE.
REQ-014 SHALL treat entry i as matching iff valid & ((lkup_ip & mask) == (prefix & mask)).
REQ-015 SHALL keep the best match as the largest netmask (unsigned compare, strictly greater); equal masks keep lowest index.
REQ-016 SHALL match mask 0x00000000 with valid=1 (default route) against any IP, lowest priority.
REQ-017 SHALL in DONE pulse lkup_done for exactly one cycle with lkup_hit/nh/oq/mask; on miss: hit=0, nh/oq/mask=0.
REQ-018 SHALL hold lkup_hit/nh/oq/mask stable from done until the next lkup_done.
REQ-019 SHALL with no host traffic pulse lkup_done in cycle T+NUM_ENTRIES+1 (T+33 at default).
REQ-020 SHALL give host accesses priority: a cycle used by a host access stalls scan (index not advanced); each such cycle adds 1 to lookup latency.
REQ-021 SHALL latch host request pulses into pending flags; one host access served per cycle, write before read.
REQ-022 SHALL pulse tbl_wr_ack one cycle after the write is performed; tbl_rd_ack with tbl_rd_data one cycle after the read.
REQ-023 SHALL serve a simultaneous wr+rd to the same address write first, so the read returns new data; both acks within 2 cycles of the request.
REQ-024 SHALL let a write to an index already scanned not affect the current result; a write to an unscanned index is seen.
REQ-025 SHALL increment lpm_miss_count by 1 on each lkup_done with hit=0; wraps 0xFFFFFFFF -> 0.
REQ-026 SHALL clear lpm_miss_count on miss_clr; clear wins over a same-cycle increment.
REQ-027 SHALL ignore lkup_req outside IDLE (no queuing); the host guarantees >=2 cycles between same-kind requests.

Reset
REQ-028 SHALL on reset force IDLE; lkup_done, lkup_hit, tbl_wr_ack, tbl_rd_ack = 0; lkup_nh/oq/mask, tbl_rd_data, lpm_miss_count = 0; pending flags cleared.
REQ-029 SHALL not clear table contents on reset; software rewrites entries.
REQ-030 SHALL on reset mid-SCAN abort without lkup_done or counter update; lkup_ready = 1 the first cycle after reset deasserts.

Verification
REQ-031 SHALL cover: all 32 entries written with valid=0, lookup 10.0.0.1 -> done at T+33, hit=0, lpm_miss_count=1.
REQ-032 SHALL cover: entry 3 = 10.0.0.0/255.0.0.0 (nh 1, oq 2), entry 7 = 10.1.0.0/255.255.0.0 (nh 5, oq 4), lookup 10.1.2.3 -> hit=1, nh=5, oq=4, mask 0xFFFF0000.
REQ-033 SHALL cover: entries 2 and 9 both 0.0.0.0/0 valid (oq 1, oq 3), lookup 192.168.1.1 -> oq=1.
REQ-034 SHALL cover: 4 host reads issued during scan -> each ack 1 cycle after service, lkup_done at T+37, result unchanged.
REQ-035 SHALL cover: wr+rd same cycle to address 5 -> tbl_rd_data equals the written value; miss_clr same cycle as a miss -> count 0.
REQ-036 SHALL cover: reset asserted at scan index 10 -> no lkup_done, count unchanged at 0, lkup_ready=1 after release, table contents retained.
